// File: rtl/vjtag_bridge_pkg.sv
// Shared instruction codes and decoded-instruction type for the virtual JTAG register bridge.
package vjtag_bridge_pkg;

    localparam int unsigned IR_CODE_W = 3;

    // Codes are zero-extended by users whose IR is wider than the minimum.
    localparam logic [IR_CODE_W-1:0] IR_BYPASS = 3'd0;
    localparam logic [IR_CODE_W-1:0] IR_ADDR   = 3'd1;
    localparam logic [IR_CODE_W-1:0] IR_WRITE  = 3'd2;
    localparam logic [IR_CODE_W-1:0] IR_READ   = 3'd3;

    typedef enum logic [1:0] {
        INSTR_BYPASS,
        INSTR_ADDR,
        INSTR_WRITE,
        INSTR_READ
    } instr_e;

endpackage

// File: rtl/vjtag_shift_reg.sv
// Parallel-load, LSB-first serial shift register used for the bridge's DR paths.
module vjtag_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             sdi_i,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] par_o,
    output logic             sdo_o
);

    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_q;

    always_comb begin
        sr_d = sr_q;
        if (capture_i) begin
            sr_d = par_i;
        end else if (shift_i) begin
            sr_d            = sr_q >> 1;
            sr_d[WIDTH-1]   = sdi_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_o = sr_q;
    assign sdo_o = sr_q[0];

endmodule

// File: rtl/vjtag_reg_bridge.sv
// Register-access bridge behind a virtual JTAG instance (TCK domain).
// Optional feature: define VJTAG_BRIDGE_AUTOINC_EN to auto-increment addr_o after WRITE/READ updates.
module vjtag_reg_bridge
    import vjtag_bridge_pkg::*;
#(
    parameter int unsigned IR_W   = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    input  logic [IR_W-1:0]   ir_in_i,
    output logic [IR_W-1:0]   ir_out_o,
    input  logic              vs_cdr_i,
    input  logic              vs_sdr_i,
    input  logic              vs_udr_i,
    input  logic              vs_uir_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic [DATA_W-1:0] rd_data_i
);

    instr_e instr;
    logic   cdr, sdr, udr, uir;

    logic              addr_cap, addr_shift, addr_sdo;
    logic              data_cap, data_shift, data_sdo;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] data_par_in;

    logic              bypass_d, bypass_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wr_data_d, wr_data_q;
    logic              wr_en_d, wr_en_q;
    logic [IR_W-1:0]   ir_out_d, ir_out_q;
    logic              scan_valid_d, scan_valid_q;
`ifdef VJTAG_BRIDGE_AUTOINC_EN
    logic              rd_done_d, rd_done_q;
`endif

    always_comb begin
        instr = INSTR_BYPASS;
        if (ir_in_i == IR_W'(IR_ADDR)) begin
            instr = INSTR_ADDR;
        end else if (ir_in_i == IR_W'(IR_WRITE)) begin
            instr = INSTR_WRITE;
        end else if (ir_in_i == IR_W'(IR_READ)) begin
            instr = INSTR_READ;
        end
    end

    // Illegal simultaneous state flags resolve as cdr > sdr > udr > uir.
    assign cdr = vs_cdr_i;
    assign sdr = vs_sdr_i & ~vs_cdr_i;
    assign udr = vs_udr_i & ~vs_cdr_i & ~vs_sdr_i;
    assign uir = vs_uir_i & ~vs_cdr_i & ~vs_sdr_i & ~vs_udr_i;

    assign addr_cap    = cdr & (instr == INSTR_ADDR);
    assign addr_shift  = sdr & (instr == INSTR_ADDR);
    assign data_cap    = cdr & ((instr == INSTR_WRITE) | (instr == INSTR_READ));
    assign data_shift  = sdr & ((instr == INSTR_WRITE) | (instr == INSTR_READ));
    assign data_par_in = (instr == INSTR_READ) ? rd_data_i : '0;

    vjtag_shift_reg #(.WIDTH(ADDR_W)) u_addr_sr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (addr_cap),
        .shift_i   (addr_shift),
        .sdi_i     (tdi_i),
        .par_i     (addr_q),
        .par_o     (addr_sr),
        .sdo_o     (addr_sdo)
    );

    vjtag_shift_reg #(.WIDTH(DATA_W)) u_data_sr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (data_cap),
        .shift_i   (data_shift),
        .sdi_i     (tdi_i),
        .par_i     (data_par_in),
        .par_o     (data_sr),
        .sdo_o     (data_sdo)
    );

    // An update only acts on a scan that began with a capture since the last reset.
    always_comb begin
        bypass_d     = bypass_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        ir_out_d     = ir_out_q;
        scan_valid_d = scan_valid_q;
`ifdef VJTAG_BRIDGE_AUTOINC_EN
        rd_done_d    = 1'b0;
        if (wr_en_q || rd_done_q) begin
            addr_d = addr_q + 1'b1;
        end
`endif
        if (cdr) begin
            scan_valid_d = 1'b1;
            if (instr == INSTR_BYPASS) begin
                bypass_d = 1'b0;
            end
        end else if (sdr) begin
            if (instr == INSTR_BYPASS) begin
                bypass_d = tdi_i;
            end
        end else if (udr) begin
            scan_valid_d = 1'b0;
            if (scan_valid_q) begin
                case (instr)
                    INSTR_ADDR: addr_d = addr_sr;
                    INSTR_WRITE: begin
                        wr_data_d = data_sr;
                        wr_en_d   = 1'b1;
                    end
`ifdef VJTAG_BRIDGE_AUTOINC_EN
                    INSTR_READ: rd_done_d = 1'b1;
`endif
                    default: ;
                endcase
            end
        end else if (uir) begin
            scan_valid_d = 1'b0;
            ir_out_d     = ir_in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bypass_q     <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            ir_out_q     <= '0;
            scan_valid_q <= 1'b0;
`ifdef VJTAG_BRIDGE_AUTOINC_EN
            rd_done_q    <= 1'b0;
`endif
        end else begin
            bypass_q     <= bypass_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            ir_out_q     <= ir_out_d;
            scan_valid_q <= scan_valid_d;
`ifdef VJTAG_BRIDGE_AUTOINC_EN
            rd_done_q    <= rd_done_d;
`endif
        end
    end

    always_comb begin
        case (instr)
            INSTR_ADDR:               tdo_o = addr_sdo;
            INSTR_WRITE, INSTR_READ:  tdo_o = data_sdo;
            default:                  tdo_o = bypass_q;
        endcase
    end

    assign ir_out_o  = ir_out_q;
    assign wr_en_o   = wr_en_q;
    assign addr_o    = addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_vjtag_reg_bridge.sv
// Directed bench for vjtag_reg_bridge; write strobes are checked against a queue of expected transactions.
module tb_vjtag_reg_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tdi_i;
    logic        tdo_o;
    logic [2:0]  ir_in_i;
    logic [2:0]  ir_out_o;
    logic        vs_cdr_i, vs_sdr_i, vs_udr_i, vs_uir_i;
    logic        wr_en_o;
    logic [3:0]  addr_o;
    logic [31:0] wr_data_o;
    logic [31:0] rd_data_i;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    vjtag_reg_bridge #(.IR_W(3), .ADDR_W(4), .DATA_W(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tdi_i     (tdi_i),
        .tdo_o     (tdo_o),
        .ir_in_i   (ir_in_i),
        .ir_out_o  (ir_out_o),
        .vs_cdr_i  (vs_cdr_i),
        .vs_sdr_i  (vs_sdr_i),
        .vs_udr_i  (vs_udr_i),
        .vs_uir_i  (vs_uir_i),
        .wr_en_o   (wr_en_o),
        .addr_o    (addr_o),
        .wr_data_o (wr_data_o),
        .rd_data_i (rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every clock advance goes through here so no strobe can slip by unchecked.
    task automatic tick();
        wr_t exp;
        @(posedge clk_i);
        #1;
        if (wr_en_o === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("[TB] FAIL unexpected_strobe observed addr=%0h data=%0h expected no strobe", addr_o, wr_data_o);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check_output("strobe_addr", 64'(addr_o), 64'(exp.addr));
                check_output("strobe_data", 64'(wr_data_o), 64'(exp.data));
            end
        end
    endtask

    task automatic ir_scan(input logic [2:0] code);
        ir_in_i  = code;
        vs_uir_i = 1'b1;
        tick();
        vs_uir_i = 1'b0;
    endtask

    // dout[i] is tdo_o sampled before the i-th shift; dout[n] is sampled after the last shift.
    task automatic apply_stimulus(input int n, input logic [31:0] din, output logic [32:0] dout);
        dout     = '0;
        vs_cdr_i = 1'b1;
        tick();
        vs_cdr_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            dout[i]  = tdo_o;
            tdi_i    = din[i];
            vs_sdr_i = 1'b1;
            tick();
        end
        vs_sdr_i = 1'b0;
        dout[n]  = tdo_o;
        vs_udr_i = 1'b1;
        tick();
        vs_udr_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [32:0] dout;
        logic [3:0]  exp_addr;
        logic [31:0] rd_word;

        rst_i = 1'b1; tdi_i = 1'b0; ir_in_i = 3'd0; rd_data_i = '0;
        vs_cdr_i = 1'b0; vs_sdr_i = 1'b0; vs_udr_i = 1'b0; vs_uir_i = 1'b0;
        tick();
        tick();
        check_output("rst_tdo",     64'(tdo_o),     64'd0);
        check_output("rst_ir_out",  64'(ir_out_o),  64'd0);
        check_output("rst_wr_en",   64'(wr_en_o),   64'd0);
        check_output("rst_addr",    64'(addr_o),    64'd0);
        check_output("rst_wr_data", 64'(wr_data_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Address then write.
        ir_scan(3'd1);
        check_output("ir_echo_addr", 64'(ir_out_o), 64'd1);
        apply_stimulus(4, 32'h5, dout);
        check_output("addr_after_scan", 64'(addr_o), 64'h5);
        ir_scan(3'd2);
        check_output("ir_echo_write", 64'(ir_out_o), 64'd2);
        exp_q.push_back('{addr: 4'h5, data: 32'hDEADBEEF});
        apply_stimulus(32, 32'hDEADBEEF, dout);
        check_output("wr_data_hold", 64'(wr_data_o), 64'hDEADBEEF);
        check_output("wr_en_low", 64'(wr_en_o), 64'd0);

        // Read from address 3.
        ir_scan(3'd1);
        apply_stimulus(4, 32'h3, dout);
        check_output("addr_for_read", 64'(addr_o), 64'h3);
        rd_word   = 32'hA5A5_0001;
        rd_data_i = rd_word;
        ir_scan(3'd3);
        apply_stimulus(32, 32'h0, dout);
        check_output("read_first_bit", 64'(dout[0]), 64'd1);
        check_output("read_word", 64'(dout[31:0]), 64'(rd_word));
`ifdef VJTAG_BRIDGE_AUTOINC_EN
        exp_addr = 4'h4;
`else
        exp_addr = 4'h3;
`endif
        check_output("addr_after_read", 64'(addr_o), 64'(exp_addr));

        // Address capture returns the current address while loading 0xF.
        ir_scan(3'd1);
        apply_stimulus(4, 32'hF, dout);
        check_output("addr_capture", 64'(dout[3:0]), 64'(exp_addr));
        check_output("addr_f", 64'(addr_o), 64'hF);

        // Two writes from address 15.
        ir_scan(3'd2);
        exp_q.push_back('{addr: 4'hF, data: 32'h1111_1111});
        apply_stimulus(32, 32'h1111_1111, dout);
`ifdef VJTAG_BRIDGE_AUTOINC_EN
        exp_q.push_back('{addr: 4'h0, data: 32'h2222_2222});
        exp_addr = 4'h1;
`else
        exp_q.push_back('{addr: 4'hF, data: 32'h2222_2222});
        exp_addr = 4'hF;
`endif
        apply_stimulus(32, 32'h2222_2222, dout);
        check_output("addr_after_burst", 64'(addr_o), 64'(exp_addr));

        // Undefined instruction behaves as bypass.
        ir_scan(3'd7);
        check_output("ir_echo_7", 64'(ir_out_o), 64'd7);
        apply_stimulus(8, 32'hB2, dout);
        check_output("bypass_capture", 64'(dout[0]), 64'd0);
        check_output("bypass_delay", 64'(dout[8:1]), 64'hB2);

        // Reset in the middle of a write scan.
        ir_scan(3'd2);
        vs_cdr_i = 1'b1;
        tick();
        vs_cdr_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tdi_i    = i[0];
            vs_sdr_i = 1'b1;
            tick();
        end
        vs_sdr_i = 1'b0;
        rst_i    = 1'b1;
        tick();
        rst_i    = 1'b0;
        vs_udr_i = 1'b1;
        tick();
        vs_udr_i = 1'b0;
        tick();
        check_output("midscan_addr", 64'(addr_o), 64'd0);
        check_output("midscan_wr_en", 64'(wr_en_o), 64'd0);
        exp_q.push_back('{addr: 4'h0, data: 32'hCAFE_F00D});
        apply_stimulus(32, 32'hCAFE_F00D, dout);

        tick();
        check_output("strobes_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
